// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel mode/edit controller for the mm:ss clock
//
// Sequences RUN -> SET_MIN -> SET_SEC -> RUN from the mode button and edits a
// private copy of the time with the inc button. The counter is frozen while
// editing and reloaded on exit from SET_SEC. Inactivity in a SET state returns
// to RUN and discards the edit. All outputs are registered.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   btn_mode, btn_inc       debounced button levels, active-high
//   blink_tick              one-cycle pulse at the blink rate
//   cur_mX..cur_sU          running time from the counter, BCD
//   disp_mX..disp_sU        BCD digits to the display multiplexer
//   digit_en                per-digit enable, bit3 = mX .. bit0 = sU
//   run_en                  counter count-enable
//   load, load_mX..load_sU  one-cycle reload strobe and reload value

module time_set_ctrl #(
   parameter int unsigned TIMEOUT_TICKS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       blink_tick,
   input  logic [3:0] cur_mX,
   input  logic [3:0] cur_mU,
   input  logic [3:0] cur_sX,
   input  logic [3:0] cur_sU,
   output logic [3:0] disp_mX,
   output logic [3:0] disp_mU,
   output logic [3:0] disp_sX,
   output logic [3:0] disp_sU,
   output logic [3:0] digit_en,
   output logic       run_en,
   output logic       load,
   output logic [3:0] load_mX,
   output logic [3:0] load_mU,
   output logic [3:0] load_sX,
   output logic [3:0] load_sU
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_MIN = 2'd1,
      ST_SET_SEC = 2'd2
   } state_e;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_TICKS);

   state_e      state_q, state_d;
   logic        btn_mode_q, btn_inc_q;
   logic [7:0]  ed_m_q, ed_m_d;        // edit minutes {tens, units}
   logic [7:0]  ed_s_q, ed_s_d;        // edit seconds {tens, units}
   logic        blink_q, blink_d;
   logic [7:0]  idle_q, idle_d;
   logic        run_en_q, run_en_d;
   logic        load_q, load_d;
   logic [15:0] load_val_q, load_val_d;
   logic [15:0] disp_q, disp_d;
   logic [3:0]  digit_en_q, digit_en_d;

   logic        mode_press, inc_press;
   logic [7:0]  cur_m, cur_s;

   assign mode_press = btn_mode & ~btn_mode_q;
   assign inc_press  = btn_inc & ~btn_inc_q;
   assign cur_m      = {cur_mX, cur_mU};
   assign cur_s      = {cur_sX, cur_sU};

   // BCD +1 with 59 -> 00 wrap.
   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] >= 4'd5) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r[7:4] = v[7:4];
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   // A field that is not a legal 00..59 BCD value starts editing from 00.
   function automatic logic [7:0] bcd_clean(input logic [7:0] v);
      return (v[7:4] > 4'd5 || v[3:0] > 4'd9) ? 8'h00 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         btn_mode_q <= 1'b0;
         btn_inc_q  <= 1'b0;
         ed_m_q     <= 8'h00;
         ed_s_q     <= 8'h00;
         blink_q    <= 1'b1;
         idle_q     <= 8'd0;
         run_en_q   <= 1'b1;
         load_q     <= 1'b0;
         load_val_q <= 16'h0000;
         disp_q     <= 16'h0000;
         digit_en_q <= 4'b1111;
      end else begin
         state_q    <= state_d;
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
         ed_m_q     <= ed_m_d;
         ed_s_q     <= ed_s_d;
         blink_q    <= blink_d;
         idle_q     <= idle_d;
         run_en_q   <= run_en_d;
         load_q     <= load_d;
         load_val_q <= load_val_d;
         disp_q     <= disp_d;
         digit_en_q <= digit_en_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ed_m_d     = ed_m_q;
      ed_s_d     = ed_s_q;
      blink_d    = blink_q;
      idle_d     = idle_q;
      load_d     = 1'b0;
      load_val_d = load_val_q;

      case (state_q)
         ST_RUN: begin
            blink_d = 1'b1;
            idle_d  = 8'd0;
            if (mode_press) begin
               state_d = ST_SET_MIN;
               ed_m_d  = bcd_clean(cur_m);
               ed_s_d  = bcd_clean(cur_s);
            end
         end
         ST_SET_MIN, ST_SET_SEC: begin
            if (blink_tick) begin
               blink_d = ~blink_q;
               idle_d  = idle_q + 8'd1;
            end
            // Priority: mode press, then inc press, then timeout. A press on
            // the terminal tick clears the idle count instead of timing out.
            if (mode_press) begin
               blink_d = 1'b1;
               idle_d  = 8'd0;
               if (state_q == ST_SET_MIN) begin
                  state_d = ST_SET_SEC;
               end else begin
                  state_d    = ST_RUN;
                  load_d     = 1'b1;
                  load_val_d = {ed_m_q, ed_s_q};
               end
            end else if (inc_press) begin
               blink_d = 1'b1;
               idle_d  = 8'd0;
               if (state_q == ST_SET_MIN) ed_m_d = bcd_inc59(ed_m_q);
               else                       ed_s_d = bcd_inc59(ed_s_q);
            end else if (blink_tick && (idle_q + 8'd1 == TIMEOUT_LIM)) begin
               state_d = ST_RUN;
               blink_d = 1'b1;
               idle_d  = 8'd0;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Registered outputs follow the next state so they line up with it.
      run_en_d = (state_d == ST_RUN);
      disp_d   = (state_d == ST_RUN) ? {cur_m, cur_s} : {ed_m_d, ed_s_d};
      case (state_d)
         ST_SET_MIN: digit_en_d = {blink_d, blink_d, 2'b11};
         ST_SET_SEC: digit_en_d = {2'b11, blink_d, blink_d};
         default:    digit_en_d = 4'b1111;
      endcase
   end

   assign {disp_mX, disp_mU, disp_sX, disp_sU} = disp_q;
   assign {load_mX, load_mU, load_sX, load_sU} = load_val_q;
   assign digit_en = digit_en_q;
   assign run_en   = run_en_q;
   assign load     = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_mode, btn_inc, blink_tick;
   logic [15:0] cur;

   logic [3:0]  d0_mX, d0_mU, d0_sX, d0_sU, den0, l0_mX, l0_mU, l0_sX, l0_sU;
   logic        run0, load0;
   logic [3:0]  d1_mX, d1_mU, d1_sX, d1_sU, den1, l1_mX, l1_mU, l1_sX, l1_sU;
   logic        run1, load1;

   always #5 clk = ~clk;

   time_set_ctrl #(.TIMEOUT_TICKS(20)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .blink_tick(blink_tick),
      .cur_mX(cur[15:12]), .cur_mU(cur[11:8]), .cur_sX(cur[7:4]), .cur_sU(cur[3:0]),
      .disp_mX(d0_mX), .disp_mU(d0_mU), .disp_sX(d0_sX), .disp_sU(d0_sU),
      .digit_en(den0), .run_en(run0), .load(load0),
      .load_mX(l0_mX), .load_mU(l0_mU), .load_sX(l0_sX), .load_sU(l0_sU));

   time_set_ctrl #(.TIMEOUT_TICKS(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .blink_tick(blink_tick),
      .cur_mX(cur[15:12]), .cur_mU(cur[11:8]), .cur_sX(cur[7:4]), .cur_sU(cur[3:0]),
      .disp_mX(d1_mX), .disp_mU(d1_mU), .disp_sX(d1_sX), .disp_sU(d1_sU),
      .digit_en(den1), .run_en(run1), .load(load1),
      .load_mX(l1_mX), .load_mU(l1_mU), .load_sX(l1_sX), .load_sU(l1_sU));

   // {run_en, load, digit_en, disp, load value}
   function automatic logic [37:0] pk(input bit r, input bit l, input logic [3:0] d,
                                      input logic [15:0] disp, input logic [15:0] lv);
      return {r, l, d, disp, lv};
   endfunction

   logic [37:0] o0, o1;
   assign o0 = pk(run0, load0, den0, {d0_mX, d0_mU, d0_sX, d0_sU}, {l0_mX, l0_mU, l0_sX, l0_sU});
   assign o1 = pk(run1, load1, den1, {d1_mX, d1_mU, d1_sX, d1_sU}, {l1_mX, l1_mU, l1_sX, l1_sU});

   localparam logic [37:0] RST_OUT = {1'b1, 1'b0, 4'hF, 16'h0000, 16'h0000};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: time held as integers, mode as 0=RUN 1=SET_MIN 2=SET_SEC.
   typedef struct {
      int          mode;
      int          mins, secs, idle;
      bit          phase, pm, pi, run_en, load;
      logic [15:0] loadv, disp;
      logic [3:0]  den;
   } mdl_t;

   function automatic mdl_t mreset();
      mdl_t m;
      m.mode = 0; m.mins = 0; m.secs = 0; m.idle = 0;
      m.phase = 1; m.pm = 0; m.pi = 0; m.run_en = 1; m.load = 0;
      m.loadv = 16'h0; m.disp = 16'h0; m.den = 4'hF;
      return m;
   endfunction

   function automatic logic [15:0] enc(input int mi, input int se);
      return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
   endfunction

   function automatic int dec(input logic [7:0] f);
      if (f[7:4] > 4'd5 || f[3:0] > 4'd9) return 0;
      return 10 * int'(f[7:4]) + int'(f[3:0]);
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit bm, input bit bi, input bit bt,
                                  input logic [15:0] c, input int tmo);
      bit mp, ip;
      mp = bm && !m.pm;
      ip = bi && !m.pi;
      m.pm = bm; m.pi = bi; m.load = 0;
      if (m.mode == 0) begin
         if (mp) begin
            m.mode = 1; m.mins = dec(c[15:8]); m.secs = dec(c[7:0]);
            m.phase = 1; m.idle = 0;
         end
      end else if (mp) begin
         m.phase = 1; m.idle = 0;
         if (m.mode == 1) m.mode = 2;
         else begin
            m.mode = 0; m.load = 1; m.loadv = enc(m.mins, m.secs);
         end
      end else if (ip) begin
         m.phase = 1; m.idle = 0;
         if (m.mode == 1) m.mins = (m.mins + 1) % 60;
         else             m.secs = (m.secs + 1) % 60;
      end else if (bt) begin
         m.phase = !m.phase; m.idle++;
         if (m.idle == tmo) begin
            m.mode = 0; m.idle = 0; m.phase = 1;
         end
      end
      m.run_en = (m.mode == 0);
      m.disp   = (m.mode == 0) ? c : enc(m.mins, m.secs);
      m.den    = (m.mode == 1) ? {m.phase, m.phase, 2'b11} :
                 (m.mode == 2) ? {2'b11, m.phase, m.phase} : 4'hF;
      return m;
   endfunction

   mdl_t m0, m1;

   // Called at a negedge: drive inputs, clock once, compare both DUTs to the model.
   task automatic step(input bit bm, input bit bi, input bit bt, input logic [15:0] c);
      btn_mode = bm; btn_inc = bi; blink_tick = bt; cur = c;
      @(posedge clk);
      m0 = mstep(m0, bm, bi, bt, c, 20);
      m1 = mstep(m1, bm, bi, bt, c, 3);
      @(negedge clk);
      check("model_t20", o0, pk(m0.run_en, m0.load, m0.den, m0.disp, m0.loadv));
      check("model_t3",  o1, pk(m1.run_en, m1.load, m1.den, m1.disp, m1.loadv));
   endtask

   task automatic do_reset();
      btn_mode = 0; btn_inc = 0; blink_tick = 0;
      rst_n = 0;
      #1;
      check("async_reset0", o0, RST_OUT);
      check("async_reset1", o1, RST_OUT);
      @(negedge clk);
      rst_n = 1;
      m0 = mreset(); m1 = mreset();
   endtask

   typedef struct {
      bit          bm, bi, bt;
      logic [15:0] c;
      bit          run_en, load;
      logic [3:0]  den;
      logic [15:0] disp, loadv;
   } vec_t;

   vec_t tbl[14];
   bit   bm_r, bi_r, quiet;
   logic [15:0] c_r;

   initial begin
      rst_n = 0; btn_mode = 0; btn_inc = 0; blink_tick = 0; cur = 16'h0000;
      m0 = mreset(); m1 = mreset();
      @(negedge clk);
      check("reset_state", o0, RST_OUT);

      // Release with 12:34 on the counter.
      cur = 16'h1234; rst_n = 1;
      step(0, 0, 0, 16'h1234);
      check("release_1234", o0, pk(1, 0, 4'hF, 16'h1234, 16'h0000));

      // 59:58: edit minutes 59 -> 00, seconds 58 -> 59 -> 00, reload.
      tbl[0]  = '{0, 0, 0, 16'h5958, 1, 0, 4'hF, 16'h5958, 16'h0000};
      tbl[1]  = '{1, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h5958, 16'h0000};
      tbl[2]  = '{0, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h5958, 16'h0000};
      tbl[3]  = '{0, 1, 0, 16'h5958, 0, 0, 4'hF, 16'h0058, 16'h0000};
      tbl[4]  = '{0, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h0058, 16'h0000};
      tbl[5]  = '{1, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h0058, 16'h0000};
      tbl[6]  = '{0, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h0058, 16'h0000};
      tbl[7]  = '{0, 1, 0, 16'h5958, 0, 0, 4'hF, 16'h0059, 16'h0000};
      tbl[8]  = '{0, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h0059, 16'h0000};
      tbl[9]  = '{0, 1, 0, 16'h5958, 0, 0, 4'hF, 16'h0000, 16'h0000};
      tbl[10] = '{0, 0, 0, 16'h5958, 0, 0, 4'hF, 16'h0000, 16'h0000};
      tbl[11] = '{1, 0, 0, 16'h1234, 1, 1, 4'hF, 16'h1234, 16'h0000};
      tbl[12] = '{0, 0, 0, 16'h1234, 1, 0, 4'hF, 16'h1234, 16'h0000};
      tbl[13] = '{0, 1, 0, 16'h1234, 1, 0, 4'hF, 16'h1234, 16'h0000};
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].bm, tbl[i].bi, tbl[i].bt, tbl[i].c);
         check($sformatf("table_%0d", i), o0,
               pk(tbl[i].run_en, tbl[i].load, tbl[i].den, tbl[i].disp, tbl[i].loadv));
      end

      // Held inc gives one increment; simultaneous mode+inc is a mode press.
      step(0, 0, 0, 16'h0730);
      step(1, 0, 0, 16'h0730);
      step(0, 0, 0, 16'h0730);
      for (int i = 0; i < 100; i++) step(0, 1, 0, 16'h0730);
      check("held_inc", o0, pk(0, 0, 4'hF, 16'h0830, 16'h0000));
      step(0, 0, 0, 16'h0730);
      step(1, 1, 0, 16'h0730);
      check("mode_beats_inc", o0, pk(0, 0, 4'hF, 16'h0830, 16'h0000));
      step(0, 0, 0, 16'h0730);
      step(1, 0, 0, 16'h0730);
      check("load_0830", o0, pk(1, 1, 4'hF, 16'h0730, 16'h0830));
      step(0, 0, 0, 16'h0730);
      check("load_one_cycle", o0, pk(1, 0, 4'hF, 16'h0730, 16'h0830));

      // Blink in SET_MIN.
      do_reset();
      step(1, 0, 0, 16'h1111);
      step(0, 0, 0, 16'h1111);
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 1, 16'h1111);
         check($sformatf("blink_tick_%0d", k), {34'd0, den0}, {34'd0, (k % 2 == 1) ? 4'b0011 : 4'b1111});
         step(0, 0, 0, 16'h1111);
      end
      step(0, 1, 0, 16'h1111);
      check("blink_inc_forces_on", {34'd0, den0}, {34'd0, 4'b1111});

      // Timeout with TIMEOUT_TICKS = 3, then a press on the terminal tick.
      do_reset();
      step(1, 0, 0, 16'h2233); step(0, 0, 0, 16'h2233);
      step(1, 0, 0, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      check("pre_timeout", {37'd0, run1}, 38'd0);
      step(0, 0, 1, 16'h2233);
      check("timeout_exit", o1, pk(1, 0, 4'hF, 16'h2233, 16'h0000));
      step(0, 0, 0, 16'h4455);
      check("timeout_tracks_cur", o1, pk(1, 0, 4'hF, 16'h4455, 16'h0000));
      step(1, 0, 0, 16'h2233); step(0, 0, 0, 16'h2233);
      step(1, 0, 0, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 1, 1, 16'h2233);
      check("press_beats_timeout", o1, pk(0, 0, 4'hF, 16'h2234, 16'h0000));
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233); step(0, 0, 0, 16'h2233);
      step(0, 0, 1, 16'h2233);
      check("timeout_after_clear", o1, pk(1, 0, 4'hF, 16'h2233, 16'h0000));

      // Reset mid-edit, then invalid seconds on entry.
      do_reset();
      step(1, 0, 0, 16'h1259); step(0, 0, 0, 16'h1259);
      step(1, 0, 0, 16'h1259); step(0, 0, 0, 16'h1259);
      step(0, 1, 0, 16'h1259);
      check("edit_sec_wrap", o0, pk(0, 0, 4'hF, 16'h1200, 16'h0000));
      step(0, 0, 0, 16'h1259);
      rst_n = 0;
      #1;
      check("midedit_async_reset", o0, RST_OUT);
      @(posedge clk); #1;
      check("midedit_reset_held", o0, RST_OUT);
      @(negedge clk);
      rst_n = 1;
      m0 = mreset(); m1 = mreset();
      step(0, 0, 0, 16'h1275);
      check("post_reset_run", o0, pk(1, 0, 4'hF, 16'h1275, 16'h0000));
      step(1, 0, 0, 16'h1275);
      check("invalid_sec_capture", o0, pk(0, 0, 4'hF, 16'h1200, 16'h0000));
      step(0, 0, 0, 16'h1275); step(1, 0, 0, 16'h1275);
      step(0, 0, 0, 16'h1275); step(1, 0, 0, 16'h1275);
      check("load_1200", o0, pk(1, 1, 4'hF, 16'h1275, 16'h1200));

      // Randomized traffic against the model; every third segment is quiet.
      do_reset();
      bm_r = 0; bi_r = 0;
      for (int seg = 0; seg < 12; seg++) begin
         quiet = (seg % 3 == 2);
         for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, quiet ? 79 : 3) == 0) bm_r = !bm_r;
            if ($urandom_range(0, quiet ? 79 : 1) == 0) bi_r = !bi_r;
            if ($urandom_range(0, 7) == 0) c_r = 16'($urandom);
            else c_r = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            step(bm_r, bi_r, ($urandom_range(0, 2) == 0), c_r);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel controller for the mm:ss clock.
- Sequences a RUN / SET_MIN / SET_SEC mode machine from two debounced buttons and holds an edit copy of the time.
- Freezes and reloads the time counter, and drives the four BCD digits plus per-digit enables into the 7-segment scan driver.
- Sits between the button debouncers, the time counter and the display multiplexer.

Parameters:
TIMEOUT_TICKS, 20, blink_tick pulses of button inactivity in a SET state before auto-exit to RUN with edits discarded; legal range 1..255
Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  debounced mode button level, active-high
btn_inc  in  1  debounced increment button level, active-high
blink_tick  in  1  single-cycle pulse at the blink rate (~2 Hz)
cur_mX, cur_mU, cur_sX, cur_sU  in  4 each  running time from the counter, BCD
disp_mX, disp_mU, disp_sX, disp_sU  out  4 each  BCD digits to the display multiplexer
digit_en  out  4  per-digit enable; bit3=mX … bit0=sU; 0 blanks the digit
run_en  out  1  counter count-enable
load  out  1  one-cycle strobe telling the counter to take load_m*/load_s*
load_mX, load_mU, load_sX, load_sU  out  4 each  BCD load values
Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- All outputs are registered.
- Reset values:
  - state = RUN, run_en = 1, load = 0.
  - load_* = 0, disp_* = 0, digit_en = 4'b1111.
  - blink_phase = 1, idle count = 0, button history flops = 0.
- Edge detect:
  - Each button has a history flop; press = btn & ~btn_q.
  - A level held high produces exactly one press.
  - Presses are acted on the same clock edge they are detected.
- Simultaneous mode and inc press: mode wins and inc is ignored.
- RUN state:
  - disp_* <= cur_* every cycle (one-cycle latency); digit_en = 1111; run_en = 1.
  - inc press is ignored.
  - mode press -> SET_MIN. Capture cur_* into the edit registers.
    - If minutes or seconds are invalid BCD (digit >9, or tens >5), that field captures as 00.
  - run_en <= 0 on the same edge.
- SET_MIN state:
  - inc press: minutes field +1 in BCD. U 9 -> 0 with X+1; 59 -> 00. Seconds untouched.
  - mode press -> SET_SEC.
- SET_SEC state:
  - inc press: seconds +1 in BCD, 59 -> 00. Minutes untouched.
  - mode press -> RUN. On that edge: load <= 1, load_* <= edit values, run_en <= 1.
  - load is high for exactly the following cycle, then 0.
- In both SET states: disp_* <= edit registers, so an increment is visible on disp the cycle after the press edge.
- Blink:
  - blink_phase toggles on each blink_tick while in a SET state.
  - blink_phase is forced to 1 on SET entry, on every inc press, and on every mode press.
  - The selected pair's digit_en bits = blink_phase; the other pair = 11. SET_MIN selects bits 3:2; SET_SEC selects bits 1:0.
- Timeout:
  - The 8-bit idle counter clears on any press and on SET entry.
  - It increments on blink_tick in SET states.
  - When it reaches TIMEOUT_TICKS (blink_tick edge): -> RUN, run_en <= 1, no load, edits discarded.
  - If a press and the terminal tick coincide, the press wins: counter clears, no timeout.
- Reset asserted mid-edit: edits discarded, no load pulse, the block returns to RUN.
- load is never asserted except on the SET_SEC -> RUN transition by mode press.
Test Plan:
- Reset, then release with cur = 12:34 -> cycle after release: run_en = 1, load = 0, digit_en = 1111; next cycle disp = 1,2,3,4.
- cur = 59:58; mode press, then 1 inc, then mode, then 2 inc, then mode:
  - state goes SET_MIN with minutes 00, then SET_SEC with seconds 58 -> 59 -> 00.
  - load pulses one cycle with load = 0,0,0,0; run_en was 0 throughout the edit.
- btn_inc held high 100 cycles in SET_MIN from 07 -> exactly one increment (minutes 08); btn_mode and btn_inc rising on the same cycle in SET_MIN -> SET_SEC, minutes unchanged.
- SET_MIN with 5 blink_ticks -> digit_en[3:2] alternates 00/11 starting 00 after the first tick, digit_en[1:0] stays 11; inc press forces digit_en = 1111 the next cycle.
- SET_SEC idle with TIMEOUT_TICKS = 3 -> after the 3rd blink_tick: state RUN, run_en = 1, load never asserted, disp tracks cur again. Repeat with inc coinciding with the 3rd tick -> stays in SET_SEC.
- rst_n pulsed low mid SET_SEC with edited seconds -> outputs reset asynchronously, no load pulse; cur with sX = 7 on mode entry -> seconds capture as 00.
